// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU parameters, register-zero constant and display helper
package alu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // Sign-extend an XLEN value to 64 bits for signed printing in benches
    function automatic longint sext(input logic [XLEN-1:0] v);
        return longint'({{(64-XLEN){v[XLEN-1]}}, v});
    endfunction

endpackage

// File: rtl/alu_regfile_if.sv
// rtl/alu_regfile_if.sv - operand read, issue and writeback bus of the register file
interface alu_regfile_if;
    import alu_pkg::*;

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            rs1_ready;
    logic            rs2_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_addr, wb_data,
        input  rs1, rs2, rs1_ready, rs2_ready, issue_ready
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_addr, wb_data,
        output rs1, rs2, rs1_ready, rs2_ready, issue_ready
    );

endinterface

// File: rtl/alu_scoreboard.sv
// rtl/alu_scoreboard.sv - per-register busy tracking and issue acceptance
module alu_scoreboard
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    output logic            issue_ready,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;

    assign busy = busy_q;

    // A claim is accepted if the register is free or is being freed right now
    always_comb begin
        issue_ready = (issue_rd == REG_ZERO) || !busy_q[issue_rd]
                   || (wb_valid && wb_addr == issue_rd);
    end

    // Writeback clears, a new claim sets; the claim is applied last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            if (wb_valid && wb_addr != REG_ZERO)
                busy_q[wb_addr] <= 1'b0;
            if (issue_valid && issue_ready && issue_rd != REG_ZERO)
                busy_q[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - operand register file with write-through bypass and scoreboard
module alu_regfile
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_regfile_if.slave bus
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            issue_ready;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic            rs1_ready_q, rs2_ready_q;
    logic            wb_hit1, wb_hit2;

    alu_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .wb_valid    (bus.wb_valid),
        .wb_addr     (bus.wb_addr),
        .issue_ready (issue_ready),
        .busy        (busy)
    );

    assign bus.issue_ready = issue_ready;
    assign bus.rs1         = rs1_q;
    assign bus.rs2         = rs2_q;
    assign bus.rs1_ready   = rs1_ready_q;
    assign bus.rs2_ready   = rs2_ready_q;

    // Same-cycle writeback matches per source port
    always_comb begin
        wb_hit1 = bus.wb_valid && (bus.wb_addr == bus.rs1_addr);
        wb_hit2 = bus.wb_valid && (bus.wb_addr == bus.rs2_addr);
    end

    // Data array; register 0 is never written so it stays zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (bus.wb_valid && bus.wb_addr != REG_ZERO) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Registered operand read with write-through bypass of the current writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_ready_q <= 1'b1;
            rs2_ready_q <= 1'b1;
        end else begin
            rs1_q       <= (wb_hit1 && bus.rs1_addr != REG_ZERO) ? bus.wb_data : regs[bus.rs1_addr];
            rs2_q       <= (wb_hit2 && bus.rs2_addr != REG_ZERO) ? bus.wb_data : regs[bus.rs2_addr];
            rs1_ready_q <= !busy[bus.rs1_addr] || wb_hit1;
            rs2_ready_q <= !busy[bus.rs2_addr] || wb_hit2;
        end
    end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - randomized and directed self-checking bench for alu_regfile
module tb_alu_regfile;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    alu_regfile_if rf ();

    alu_regfile dut (.clk(clk), .rst(rst), .bus(rf));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    logic [XLEN-1:0] e_rs1, e_rs2;
    logic            e_rdy1, e_rdy2;
    logic            got_iready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check issue_ready, advance the model, check outputs
    task automatic step(input logic r, input int a1, input int a2,
                        input logic iv, input int rd,
                        input logic wv, input int wa, input logic [XLEN-1:0] wd);
        logic e_iready;
        rst            = r;
        rf.rs1_addr    = AW'(a1);
        rf.rs2_addr    = AW'(a2);
        rf.issue_valid = iv;
        rf.issue_rd    = AW'(rd);
        rf.wb_valid    = wv;
        rf.wb_addr     = AW'(wa);
        rf.wb_data     = wd;
        #1;
        e_iready   = (rd == 0) || !m_busy[rd] || (wv && wa == rd);
        got_iready = rf.issue_ready;
        if (!r) chk("issue_ready", 64'(got_iready), 64'(e_iready));
        if (r) begin
            foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 0; end
            e_rs1 = '0; e_rs2 = '0; e_rdy1 = 1; e_rdy2 = 1;
        end else begin
            e_rs1  = (a1 != 0 && wv && wa == a1) ? wd : m_regs[a1];
            e_rs2  = (a2 != 0 && wv && wa == a2) ? wd : m_regs[a2];
            e_rdy1 = !m_busy[a1] || (wv && wa == a1);
            e_rdy2 = !m_busy[a2] || (wv && wa == a2);
            if (wv && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 0; end
            if (iv && e_iready && rd != 0) m_busy[rd] = 1;
        end
        @(posedge clk);
        #1;
        chk("rs1", 64'(rf.rs1), 64'(e_rs1));
        chk("rs2", 64'(rf.rs2), 64'(e_rs2));
        chk("rs1_ready", 64'(rf.rs1_ready), 64'(e_rdy1));
        chk("rs2_ready", 64'(rf.rs2_ready), 64'(e_rdy2));
    endtask

    initial begin
        foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 0; end
        // reset then read 0/0
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_reset_rs1", 64'(rf.rs1), 64'd0);
        chk("lit_reset_rdy", 64'({rf.rs1_ready, rf.rs2_ready}), 64'b11);
        // writeback to register 0 is discarded, bypass included
        step(0, 0, 0, 0, 0, 1, 0, 32'd1234);
        chk("lit_wb0_bypass", 64'(rf.rs1), 64'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_wb0_read", 64'(rf.rs1), 64'd0);
        // bypass then stored value
        step(0, 3, 0, 0, 0, 1, 3, 32'hFFFF_FFFF);
        chk("lit_bypass3", 64'(rf.rs1), 64'hFFFF_FFFF);
        step(0, 3, 3, 0, 0, 0, 0, 0);
        chk("lit_read3_rs1", 64'(rf.rs1), 64'hFFFF_FFFF);
        chk("lit_read3_rs2", 64'(rf.rs2), 64'hFFFF_FFFF);
        // claim reg 5, observe hazard, then free and reclaim in one cycle
        step(0, 0, 0, 1, 5, 0, 0, 0);
        chk("lit_issue5", 64'(got_iready), 64'd1);
        step(0, 5, 0, 1, 5, 0, 0, 0);
        chk("lit_issue5_again", 64'(got_iready), 64'd0);
        chk("lit_rs1_ready5", 64'(rf.rs1_ready), 64'd0);
        step(0, 5, 0, 1, 5, 1, 5, 32'd21);
        chk("lit_issue5_wb", 64'(got_iready), 64'd1);
        chk("lit_rs1_5", 64'(rf.rs1), 64'd21);
        chk("lit_rs1_ready5_wb", 64'(rf.rs1_ready), 64'd1);
        // same-cycle claim and writeback to 7: claim wins
        step(0, 0, 0, 1, 7, 1, 7, 32'd10);
        step(0, 7, 0, 0, 0, 0, 0, 0);
        chk("lit_rs1_7", 64'(rf.rs1), 64'd10);
        chk("lit_rs1_ready7", 64'(rf.rs1_ready), 64'd0);
        // operands for a subtract: -10 - 10 = -20
        step(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFF6);
        step(0, 0, 0, 0, 0, 1, 2, 32'd10);
        step(0, 1, 2, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_sub_rd", 64'(sext(rf.rs1) - sext(rf.rs2)), 64'(-64'sd20));
        // mid-operation reset
        step(1, 3, 5, 1, 5, 1, 3, 32'd99);
        chk("lit_rst_rs", 64'({rf.rs1, rf.rs2}), 64'd0);
        chk("lit_rst_rdy", 64'({rf.rs1_ready, rf.rs2_ready}), 64'b11);
        step(0, 3, 5, 1, 5, 0, 0, 0);
        chk("lit_rst_issue5", 64'(got_iready), 64'd1);
        chk("lit_rst_read3", 64'(rf.rs1), 64'd0);
        // randomized traffic on a narrow address window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            int a1, a2, rd, wa;
            a1 = (($urandom % 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            a2 = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 7));
            wa = (($urandom % 3) == 0) ? rd : int'($urandom_range(0, 7));
            step(($urandom % 60) == 0, a1, a2, ($urandom % 2) == 1, rd,
                 ($urandom % 2) == 1, wa, (($urandom % 5) == 0) ? 32'hFFFF_FFFF : $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Operand register file and scoreboard feeding `alu_sub` and sibling ALU units. It holds 32 general registers of XLEN bits, supplies the rs1/rs2 operand pair one cycle after the address pair is presented, and accepts ALU results on a writeback port. A per-register busy scoreboard tracks destinations that have been issued but not yet written back, and flags operand readiness and write-after-write hazards to the issue logic.

## Interface
- `XLEN`, 32: data width of every register and both operand outputs.
- `NREG`, 32: number of registers; register 0 is hardwired to zero.
- `AW`, 5: register address width, clog2(NREG).

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs1_addr`  in  AW  source-1 read address.
- `rs2_addr`  in  AW  source-2 read address.
- `rs1`  out  XLEN  registered source-1 operand.
- `rs2`  out  XLEN  registered source-2 operand.
- `rs1_ready`  out  1  registered; `rs1` holds a committed value (not pending).
- `rs2_ready`  out  1  registered; same meaning for `rs2`.
- `issue_valid`  in  1  issue logic requests to claim `issue_rd` as a pending destination.
- `issue_rd`  in  AW  destination register being claimed.
- `issue_ready`  out  1  combinational; the claim is accepted this cycle.
- `wb_valid`  in  1  writeback strobe.
- `wb_addr`  in  AW  writeback destination.
- `wb_data`  in  XLEN  writeback value, normally the ALU `rd`.

## Operation
- State: `regs[NREG]` of XLEN bits and `busy[NREG]` of 1 bit. `regs[0]` and `busy[0]` are constant 0.
- Read path, computed each cycle for each source port n:
  - `rsN <= (wb_valid && wb_addr==rsN_addr && rsN_addr!=0) ? wb_data : regs[rsN_addr]`. This is a write-through bypass.
  - `rsN_ready <= !busy[rsN_addr] || (wb_valid && wb_addr==rsN_addr)`.
  - An address of 0 always yields data 0 and ready 1.
- Writeback: when `wb_valid` and `wb_addr!=0`:
  - `regs[wb_addr] <= wb_data`.
  - `busy[wb_addr] <= 0`, unless an issue claims the same register that cycle.
  - A writeback to 0 is discarded.
- Issue:
  - `issue_ready = (issue_rd==0) || !busy[issue_rd] || (wb_valid && wb_addr==issue_rd)`.
  - On `issue_valid && issue_ready` with `issue_rd!=0`, `busy[issue_rd] <= 1`.
  - A claim on register 0 is accepted and has no effect.
- Simultaneous issue and writeback to the same register: data is written, busy ends at 1 because the new claim wins.
- Writeback to a register that is not busy: data is written, busy stays 0. This is legal and not an error.
- Arithmetic: none. Values are stored bit-exact, with no sign or width conversion.

## Timing
- Read latency is 1 cycle. The address is sampled at edge k; data and ready are valid after edge k and until edge k+1.
- Writeback is visible to a same-cycle read through the bypass, and to every later read.
- `issue_ready` has zero latency (combinational from `issue_rd`, `busy`, and the wb inputs). Busy takes effect from the following edge.
- Reset, including mid-operation:
  - All `regs` become 0 and all `busy` become 0.
  - `rs1`/`rs2` become 0 and `rs1_ready`/`rs2_ready` become 1.
  - Any issue or wb in the reset cycle is ignored.

## Structure
- Shared package `alu_pkg` holds:
  - `XLEN`, `NREG`, and `AW` defaults.
  - The constant `REG_ZERO = 0`.
  - The helpers for sign-extended display shared with the ALU benches, alongside `alu_function.v`.
- Sub-module `alu_scoreboard` holds the `busy` vector, the `issue_ready` logic, and the set/clear priority. `alu_regfile` holds the data array and the read bypass, and instantiates it.

## Test plan
- Reset, then read 0/0 -> `rs1=0`, `rs2=0`, both ready=1. A wb of 1234 to reg 0, then a read of reg 0 -> 0.
- Write 4294967295 to reg 3. A read of reg 3 in the same cycle -> `rs1=4294967295` (bypass). The next cycle, read 3/3 -> both outputs 4294967295, ready=1.
- Issue `rd=5` -> `issue_ready=1`; the next cycle, a read of reg 5 gives `rs1_ready=0` and a second issue of `rd=5` gives `issue_ready=0`. A wb of 21 to reg 5 -> ready=1 with value 21, and an issue of `rd=5` in that same cycle -> accepted.
- Same-cycle issue and wb to reg 7 with value 10 -> reg 7 holds 10, `busy[7]=1`, and the following read gives `rs1_ready=0`.
- Write -10 (0xFFFFFFF6) to reg 1 and 10 to reg 2, then read 1/2 -> the values drive `alu_sub`, and `rd=-20` is checked at negedge.
- Assert `rst` with regs 3 and 5 busy/loaded -> after one edge, all outputs are at reset values and issue `rd=5` -> `issue_ready=1`.
